// File: rtl/ifu_fetch_queue_if.sv
// Fetch queue handshake bundle.
//   Enqueue side : enq_valid_i, enq_ready_o, enq_count_i, enq_instr_i, enq_pc_i
//   Dequeue side : deq_valid_o, deq_instr_o, deq_pc_o, deq_accept_i
// Signal suffixes are relative to the queue. The queue connects through the
// slave modport; the fetch stage and decode together drive through master.
interface ifu_fetch_queue_if #(
  parameter int INSTR_PER_FETCH = 4,
  parameter int DEQ_WIDTH       = 4,
  parameter int ILEN            = 32,
  parameter int XLEN            = 32
);
  localparam int ECW = $clog2(INSTR_PER_FETCH + 1);
  localparam int DCW = $clog2(DEQ_WIDTH + 1);

  logic                            enq_valid_i;
  logic                            enq_ready_o;
  logic [ECW-1:0]                  enq_count_i;
  logic [INSTR_PER_FETCH*ILEN-1:0] enq_instr_i;
  logic [INSTR_PER_FETCH*XLEN-1:0] enq_pc_i;
  logic [DEQ_WIDTH-1:0]            deq_valid_o;
  logic [DEQ_WIDTH*ILEN-1:0]       deq_instr_o;
  logic [DEQ_WIDTH*XLEN-1:0]       deq_pc_o;
  logic [DCW-1:0]                  deq_accept_i;

  modport master (
    output enq_valid_i, enq_count_i, enq_instr_i, enq_pc_i, deq_accept_i,
    input  enq_ready_o, deq_valid_o, deq_instr_o, deq_pc_o
  );

  modport slave (
    input  enq_valid_i, enq_count_i, enq_instr_i, enq_pc_i, deq_accept_i,
    output enq_ready_o, deq_valid_o, deq_instr_o, deq_pc_o
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Multi-lane instruction fetch queue between the fetch stage and decode.
// Accepts one packed fetch group per cycle (all-or-nothing) and presents the
// oldest DEQ_WIDTH instructions in program order. With BYPASS_EN an empty
// queue forwards the incoming group to decode in the same cycle.
// Ports:
//   clk_i   : clock, all state on rising edge
//   rst_i   : asynchronous active-high reset (control state only)
//   flush_i : redirect, discards all contents, highest priority
//   fq      : enqueue/dequeue handshake bundle (slave modport)
//   count_o : registered occupancy
module ifu_fetch_queue #(
  parameter int INSTR_PER_FETCH = 4,
  parameter int DEQ_WIDTH       = 4,
  parameter int DEPTH           = 8,
  parameter int ILEN            = 32,
  parameter int XLEN            = 32,
  parameter bit BYPASS_EN       = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  ifu_fetch_queue_if.slave           fq,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  logic [ILEN-1:0] mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  logic enq_ready;
  logic bypass;
  logic grp_accept;
  int   enq_n;
  int   vis_n;
  int   acc_n;
  int   wr_n;
  int   wr_off;
  int   deq_store_n;

  logic            wr_en    [INSTR_PER_FETCH];
  logic [PW-1:0]   wr_slot  [INSTR_PER_FETCH];
  logic [ILEN-1:0] wr_instr [INSTR_PER_FETCH];
  logic [XLEN-1:0] wr_pc    [INSTR_PER_FETCH];
  logic [PW-1:0]   rd_slot  [DEQ_WIDTH];

  always_comb begin
    // Ready looks only at registered occupancy so producers never see a
    // combinational path from decode's accept back into fetch.
    enq_ready  = (DEPTH - int'(count)) >= INSTR_PER_FETCH;
    enq_n      = min_int(int'(fq.enq_count_i), INSTR_PER_FETCH);
    grp_accept = fq.enq_valid_i && enq_ready && !flush_i;
    bypass     = BYPASS_EN && (count == '0) && fq.enq_valid_i && !flush_i && !rst_i;

    if (flush_i || rst_i) begin
      vis_n = 0;
    end else if (bypass) begin
      vis_n = min_int(enq_n, DEQ_WIDTH);
    end else begin
      vis_n = min_int(int'(count), DEQ_WIDTH);
    end
    acc_n = min_int(int'(fq.deq_accept_i), vis_n);

    // In bypass the lanes decode takes never touch storage; the leftover
    // lanes land at tail starting from the first unconsumed enqueue lane.
    if (bypass) begin
      wr_n        = enq_n - acc_n;
      wr_off      = acc_n;
      deq_store_n = 0;
    end else begin
      wr_n        = grp_accept ? enq_n : 0;
      wr_off      = 0;
      deq_store_n = acc_n;
    end

    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      wr_en[i]    = (i < wr_n);
      wr_slot[i]  = PW'(int'(tail) + i);
      wr_instr[i] = fq.enq_instr_i[min_int(wr_off + i, INSTR_PER_FETCH - 1)*ILEN +: ILEN];
      wr_pc[i]    = fq.enq_pc_i[min_int(wr_off + i, INSTR_PER_FETCH - 1)*XLEN +: XLEN];
    end

    fq.enq_ready_o = enq_ready;
    fq.deq_valid_o = '0;
    fq.deq_instr_o = '0;
    fq.deq_pc_o    = '0;
    for (int k = 0; k < DEQ_WIDTH; k++) begin
      rd_slot[k]        = PW'(int'(head) + k);
      fq.deq_valid_o[k] = (k < vis_n);
      if (bypass) begin
        fq.deq_instr_o[k*ILEN +: ILEN] =
          fq.enq_instr_i[((k < INSTR_PER_FETCH) ? k : INSTR_PER_FETCH - 1)*ILEN +: ILEN];
        fq.deq_pc_o[k*XLEN +: XLEN] =
          fq.enq_pc_i[((k < INSTR_PER_FETCH) ? k : INSTR_PER_FETCH - 1)*XLEN +: XLEN];
      end else begin
        fq.deq_instr_o[k*ILEN +: ILEN] = mem_instr[rd_slot[k]];
        fq.deq_pc_o[k*XLEN +: XLEN]    = mem_pc[rd_slot[k]];
      end
    end
  end

  // ---- control state register ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= PW'(int'(head) + deq_store_n);
      tail  <= PW'(int'(tail) + wr_n);
      count <= CW'(int'(count) + wr_n - deq_store_n);
    end
  end

  // ---- slot storage (not reset) ----
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      if (wr_en[i]) begin
        mem_instr[wr_slot[i]] <= wr_instr[i];
        mem_pc[wr_slot[i]]    <= wr_pc[i];
      end
    end
  end

  assign count_o = count;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;
  localparam int IPF   = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 8;
  localparam int ILEN  = 32;
  localparam int XLEN  = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] cnt0;
  logic [3:0] cnt1;

  always #5 clk = ~clk;

  ifu_fetch_queue_if #(.INSTR_PER_FETCH(IPF), .DEQ_WIDTH(DW), .ILEN(ILEN), .XLEN(XLEN)) if0 ();
  ifu_fetch_queue_if #(.INSTR_PER_FETCH(IPF), .DEQ_WIDTH(DW), .ILEN(ILEN), .XLEN(XLEN)) if1 ();

  ifu_fetch_queue #(.INSTR_PER_FETCH(IPF), .DEQ_WIDTH(DW), .DEPTH(DEPTH), .ILEN(ILEN),
                    .XLEN(XLEN), .BYPASS_EN(1'b0)) u_b0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .fq(if0), .count_o(cnt0));

  ifu_fetch_queue #(.INSTR_PER_FETCH(IPF), .DEQ_WIDTH(DW), .DEPTH(DEPTH), .ILEN(ILEN),
                    .XLEN(XLEN), .BYPASS_EN(1'b1)) u_b1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .fq(if1), .count_o(cnt1));

  int checks = 0;
  int errors = 0;

  // Current stimulus, driven identically into both instances.
  bit          c_flush;
  bit          c_ev;
  int          c_ecnt;
  int          c_acc;
  logic [31:0] c_pc    [IPF];
  logic [31:0] c_instr [IPF];

  // Reference model: per instance, an ordered list, oldest at index 0.
  logic [31:0] m_pc    [2][16];
  logic [31:0] m_instr [2][16];
  int          m_n     [2];

  typedef struct {
    bit          flush;
    bit          ev;
    int          ecnt;
    logic [31:0] pc0;
    int          acc;
    logic [3:0]  vld;
    int          cnt;
    bit          rdy;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit m_bypass(input int b);
    return (b == 1) && (m_n[b] == 0) && c_ev && !c_flush;
  endfunction

  function automatic int m_vis(input int b);
    if (c_flush) return 0;
    if (m_bypass(b)) return imin(c_ecnt, DW);
    return imin(m_n[b], DW);
  endfunction

  task automatic set_grp(input bit fl, input bit ev, input int ecnt, input logic [31:0] pc0,
                         input int acc);
    c_flush = fl;
    c_ev    = ev;
    c_ecnt  = ecnt;
    c_acc   = acc;
    for (int i = 0; i < IPF; i++) begin
      c_pc[i]    = pc0 + 32'(4 * i);
      c_instr[i] = $urandom;
    end
  endtask

  task automatic apply_inputs();
    flush = c_flush;
    if0.enq_valid_i = c_ev;
    if1.enq_valid_i = c_ev;
    if0.enq_count_i = 3'(c_ecnt);
    if1.enq_count_i = 3'(c_ecnt);
    if0.deq_accept_i = 3'(c_acc);
    if1.deq_accept_i = 3'(c_acc);
    for (int i = 0; i < IPF; i++) begin
      if0.enq_instr_i[i*ILEN +: ILEN] = c_instr[i];
      if1.enq_instr_i[i*ILEN +: ILEN] = c_instr[i];
      if0.enq_pc_i[i*XLEN +: XLEN]    = c_pc[i];
      if1.enq_pc_i[i*XLEN +: XLEN]    = c_pc[i];
    end
  endtask

  task automatic start_cycle();
    @(negedge clk);
    apply_inputs();
    #1;
  endtask

  // Compare both instances against the model, then advance the model by the
  // upcoming clock edge.
  task automatic check_and_advance(input string tag);
    logic [3:0]   a_vld;
    logic [127:0] a_ins;
    logic [127:0] a_pc;
    logic [3:0]   a_cnt;
    logic         a_rdy;
    bit           byp;
    bit           rdy;
    int           n;
    int           a;
    for (int b = 0; b < 2; b++) begin
      if (b == 0) begin
        a_vld = if0.deq_valid_o; a_ins = if0.deq_instr_o; a_pc = if0.deq_pc_o;
        a_cnt = cnt0; a_rdy = if0.enq_ready_o;
      end else begin
        a_vld = if1.deq_valid_o; a_ins = if1.deq_instr_o; a_pc = if1.deq_pc_o;
        a_cnt = cnt1; a_rdy = if1.enq_ready_o;
      end
      byp = m_bypass(b);
      n   = m_vis(b);
      rdy = (DEPTH - m_n[b]) >= IPF;
      chk($sformatf("%s_b%0d_vld", tag, b), 64'(a_vld), 64'((1 << n) - 1));
      chk($sformatf("%s_b%0d_cnt", tag, b), 64'(a_cnt), 64'(m_n[b]));
      chk($sformatf("%s_b%0d_rdy", tag, b), 64'(a_rdy), 64'(rdy));
      for (int k = 0; k < n; k++) begin
        chk($sformatf("%s_b%0d_pc%0d", tag, b, k), 64'(a_pc[k*32 +: 32]),
            64'(byp ? c_pc[k] : m_pc[b][k]));
        chk($sformatf("%s_b%0d_ins%0d", tag, b, k), 64'(a_ins[k*32 +: 32]),
            64'(byp ? c_instr[k] : m_instr[b][k]));
      end
      a = imin(c_acc, n);
      if (c_flush) begin
        m_n[b] = 0;
      end else if (byp) begin
        for (int i = a; i < c_ecnt; i++) begin
          m_pc[b][m_n[b]] = c_pc[i]; m_instr[b][m_n[b]] = c_instr[i]; m_n[b]++;
        end
      end else begin
        for (int i = 0; i < m_n[b] - a; i++) begin
          m_pc[b][i] = m_pc[b][i + a]; m_instr[b][i] = m_instr[b][i + a];
        end
        m_n[b] -= a;
        if (c_ev && rdy) begin
          for (int i = 0; i < c_ecnt; i++) begin
            m_pc[b][m_n[b]] = c_pc[i]; m_instr[b][m_n[b]] = c_instr[i]; m_n[b]++;
          end
        end
      end
    end
  endtask

  initial begin
    // Hand-computed expectations for the non-bypass instance, one row per cycle.
    tbl[0]  = '{0, 1, 4, 32'h8000_0000, 0, 4'b0000, 0, 1, 32'h0};
    tbl[1]  = '{0, 1, 4, 32'h8000_0010, 0, 4'b1111, 4, 1, 32'h8000_0000};
    tbl[2]  = '{0, 1, 4, 32'h8000_0020, 0, 4'b1111, 8, 0, 32'h8000_0000};
    tbl[3]  = '{0, 1, 4, 32'h8000_0020, 4, 4'b1111, 8, 0, 32'h8000_0000};
    tbl[4]  = '{0, 1, 4, 32'h8000_0020, 0, 4'b1111, 4, 1, 32'h8000_0010};
    tbl[5]  = '{1, 1, 4, 32'h9000_0000, 2, 4'b0000, 8, 0, 32'h0};
    tbl[6]  = '{0, 0, 0, 32'h0,         0, 4'b0000, 0, 1, 32'h0};
    tbl[7]  = '{0, 1, 4, 32'h0000_1000, 0, 4'b0000, 0, 1, 32'h0};
    tbl[8]  = '{0, 1, 2, 32'h0000_1010, 0, 4'b1111, 4, 1, 32'h0000_1000};
    tbl[9]  = '{0, 0, 0, 32'h0,         4, 4'b1111, 6, 0, 32'h0000_1000};
    tbl[10] = '{0, 0, 0, 32'h0,         2, 4'b0011, 2, 1, 32'h0000_1010};
    tbl[11] = '{0, 1, 4, 32'h0000_2000, 0, 4'b0000, 0, 1, 32'h0};
    tbl[12] = '{0, 1, 1, 32'h0000_3000, 0, 4'b1111, 4, 1, 32'h0000_2000};
    tbl[13] = '{1, 1, 4, 32'h0000_4000, 2, 4'b0000, 5, 0, 32'h0};
    tbl[14] = '{0, 1, 0, 32'h0000_5000, 0, 4'b0000, 0, 1, 32'h0};
    tbl[15] = '{0, 0, 0, 32'h0,         0, 4'b0000, 0, 1, 32'h0};

    m_n[0] = 0;
    m_n[1] = 0;
    rst = 1'b1;
    set_grp(0, 0, 0, 32'h0, 0);
    apply_inputs();
    #3;
    chk("rst_cnt0", 64'(cnt0), 64'(0));
    chk("rst_cnt1", 64'(cnt1), 64'(0));
    chk("rst_vld0", 64'(if0.deq_valid_o), 64'(0));
    chk("rst_vld1", 64'(if1.deq_valid_o), 64'(0));
    chk("rst_rdy0", 64'(if0.enq_ready_o), 64'(1));
    chk("rst_rdy1", 64'(if1.enq_ready_o), 64'(1));
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 16; v++) begin
      set_grp(tbl[v].flush, tbl[v].ev, tbl[v].ecnt, tbl[v].pc0, tbl[v].acc);
      start_cycle();
      chk($sformatf("tbl%0d_vld", v), 64'(if0.deq_valid_o), 64'(tbl[v].vld));
      chk($sformatf("tbl%0d_cnt", v), 64'(cnt0), 64'(tbl[v].cnt));
      chk($sformatf("tbl%0d_rdy", v), 64'(if0.enq_ready_o), 64'(tbl[v].rdy));
      if (tbl[v].vld[0]) chk($sformatf("tbl%0d_pc0", v), 64'(if0.deq_pc_o[31:0]), 64'(tbl[v].pc));
      check_and_advance($sformatf("tbl%0d", v));
    end

    // Same-cycle bypass on the empty bypass-enabled instance.
    set_grp(0, 1, 3, 32'h0000_0100, 2);
    start_cycle();
    chk("byp_vld", 64'(if1.deq_valid_o), 64'(4'b0111));
    chk("byp_pc0", 64'(if1.deq_pc_o[31:0]), 64'(32'h100));
    chk("byp_pc1", 64'(if1.deq_pc_o[63:32]), 64'(32'h104));
    check_and_advance("byp0");
    set_grp(0, 0, 0, 32'h0, 0);
    start_cycle();
    chk("byp_cnt_next", 64'(cnt1), 64'(1));
    chk("byp_lane0_next", 64'(if1.deq_pc_o[31:0]), 64'(32'h108));
    chk("nobyp_cnt_next", 64'(cnt0), 64'(3));
    check_and_advance("byp1");
    set_grp(1, 0, 0, 32'h0, 0);
    start_cycle();
    check_and_advance("byp_flush");

    // Asynchronous reset with six entries held.
    set_grp(0, 1, 4, 32'h0000_6000, 0);
    start_cycle();
    check_and_advance("ar0");
    set_grp(0, 1, 2, 32'h0000_6010, 0);
    start_cycle();
    check_and_advance("ar1");
    set_grp(0, 0, 0, 32'h0, 0);
    start_cycle();
    chk("ar_pre_cnt0", 64'(cnt0), 64'(6));
    #1;
    rst = 1'b1;
    #1;
    chk("ar_cnt0", 64'(cnt0), 64'(0));
    chk("ar_cnt1", 64'(cnt1), 64'(0));
    chk("ar_vld0", 64'(if0.deq_valid_o), 64'(0));
    chk("ar_vld1", 64'(if1.deq_valid_o), 64'(0));
    chk("ar_rdy0", 64'(if0.enq_ready_o), 64'(1));
    m_n[0] = 0;
    m_n[1] = 0;
    @(negedge clk);
    rst = 1'b0;
    set_grp(0, 1, 4, 32'h8000_0000, 0);
    start_cycle();
    check_and_advance("ar2");
    set_grp(0, 0, 0, 32'h0, 0);
    start_cycle();
    chk("ar_post_vld", 64'(if0.deq_valid_o), 64'(4'b1111));
    chk("ar_post_cnt", 64'(cnt0), 64'(4));
    chk("ar_post_pc3", 64'(if0.deq_pc_o[127:96]), 64'(32'h8000_000C));
    check_and_advance("ar3");

    // Randomized traffic against the model.
    for (int r = 0; r < 800; r++) begin
      int n0;
      int n1;
      set_grp(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
              $urandom_range(0, IPF), $urandom & 32'hFFFF_FFFC, 0);
      n0 = m_vis(0);
      n1 = m_vis(1);
      c_acc = $urandom_range(0, imin(n0, n1));
      start_cycle();
      check_and_advance($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
